// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion on
// hazards and EX flushes, and saturating stall/flush event counters.
module id_ex_hazard_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_branch,
    input  logic             id_MemRead,
    input  logic             id_MemtoReg,
    input  logic             id_MemWrite,
    input  logic             id_ALUsrc,
    input  logic             id_RegWrite,
    input  logic [1:0]       id_ALUop,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [2:0]       id_funct3,
    input  logic             id_funct7_5,
    input  logic             ex_flush,
    output logic             ex_valid,
    output logic             ex_branch,
    output logic             ex_MemRead,
    output logic             ex_MemtoReg,
    output logic             ex_MemWrite,
    output logic             ex_ALUsrc,
    output logic             ex_RegWrite,
    output logic [1:0]       ex_ALUop,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [2:0]       ex_funct3,
    output logic             ex_funct7_5,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    logic hz;

    // rs2 is checked for every consumer, including stores and branches
    always_comb begin
        hz = ex_valid & ex_MemRead & id_valid & (ex_rd != 5'd0) &
             ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    end

    assign stall = hz & ~ex_flush;

    // ID -> EX register: a bubble zeroes everything so ex_rd=0 never forwards
    always_ff @(posedge clk) begin
        if (rst || ex_flush || hz) begin
            ex_valid    <= 1'b0;
            ex_branch   <= 1'b0;
            ex_MemRead  <= 1'b0;
            ex_MemtoReg <= 1'b0;
            ex_MemWrite <= 1'b0;
            ex_ALUsrc   <= 1'b0;
            ex_RegWrite <= 1'b0;
            ex_ALUop    <= 2'b00;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= 5'd0;
            ex_rs2      <= 5'd0;
            ex_rd       <= 5'd0;
            ex_funct3   <= 3'd0;
            ex_funct7_5 <= 1'b0;
        end else begin
            ex_valid    <= id_valid;
            ex_branch   <= id_branch   & id_valid;
            ex_MemRead  <= id_MemRead  & id_valid;
            ex_MemtoReg <= id_MemtoReg & id_valid;
            ex_MemWrite <= id_MemWrite & id_valid;
            ex_ALUsrc   <= id_ALUsrc   & id_valid;
            ex_RegWrite <= id_RegWrite & id_valid;
            ex_ALUop    <= id_valid ? id_ALUop : 2'b00;
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_funct3   <= id_funct3;
            ex_funct7_5 <= id_funct7_5;
        end
    end

    // Flush outranks hazard, so at most one counter moves per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (ex_flush) begin
            flush_cnt <= sat_inc(flush_cnt);
        end else if (hz) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Randomized self-checking bench for id_ex_hazard_reg, with a second instance
// using 2-bit counters to exercise saturation.
module tb_id_ex_hazard_reg;

    typedef struct packed {
        logic        valid, branch, memread, memtoreg, memwrite, alusrc, regwrite;
        logic [1:0]  aluop;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic        f7;
    } st_t;

    logic clk = 1'b0;
    logic rst, flush;
    st_t  id, exp, act, s_act;
    int   scnt, fcnt, scnt2, fcnt2;
    int   checks = 0;
    int   errors = 0;

    logic ex_valid, ex_branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUsrc, ex_RegWrite;
    logic [1:0] ex_ALUop;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic [2:0] ex_funct3;
    logic ex_funct7_5, stall;
    logic [15:0] stall_cnt, flush_cnt;

    logic s_valid, s_branch, s_MemRead, s_MemtoReg, s_MemWrite, s_ALUsrc, s_RegWrite;
    logic [1:0] s_ALUop;
    logic [31:0] s_pc, s_rs1_data, s_rs2_data, s_imm;
    logic [4:0] s_rs1, s_rs2, s_rd;
    logic [2:0] s_funct3;
    logic s_funct7_5, s_stall;
    logic [1:0] s_stall_cnt, s_flush_cnt;

    always #5 clk = ~clk;

    assign act = {ex_valid, ex_branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUsrc,
                  ex_RegWrite, ex_ALUop, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
                  ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7_5};
    assign s_act = {s_valid, s_branch, s_MemRead, s_MemtoReg, s_MemWrite, s_ALUsrc,
                    s_RegWrite, s_ALUop, s_pc, s_rs1_data, s_rs2_data, s_imm,
                    s_rs1, s_rs2, s_rd, s_funct3, s_funct7_5};

    id_ex_hazard_reg #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id.valid), .id_branch(id.branch),
        .id_MemRead(id.memread), .id_MemtoReg(id.memtoreg), .id_MemWrite(id.memwrite),
        .id_ALUsrc(id.alusrc), .id_RegWrite(id.regwrite), .id_ALUop(id.aluop),
        .id_pc(id.pc), .id_rs1_data(id.rs1d), .id_rs2_data(id.rs2d), .id_imm(id.imm),
        .id_rs1(id.rs1), .id_rs2(id.rs2), .id_rd(id.rd), .id_funct3(id.f3),
        .id_funct7_5(id.f7), .ex_flush(flush),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_MemRead(ex_MemRead),
        .ex_MemtoReg(ex_MemtoReg), .ex_MemWrite(ex_MemWrite), .ex_ALUsrc(ex_ALUsrc),
        .ex_RegWrite(ex_RegWrite), .ex_ALUop(ex_ALUop), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
        .ex_funct7_5(ex_funct7_5), .stall(stall), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    id_ex_hazard_reg #(.XLEN(32), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id.valid), .id_branch(id.branch),
        .id_MemRead(id.memread), .id_MemtoReg(id.memtoreg), .id_MemWrite(id.memwrite),
        .id_ALUsrc(id.alusrc), .id_RegWrite(id.regwrite), .id_ALUop(id.aluop),
        .id_pc(id.pc), .id_rs1_data(id.rs1d), .id_rs2_data(id.rs2d), .id_imm(id.imm),
        .id_rs1(id.rs1), .id_rs2(id.rs2), .id_rd(id.rd), .id_funct3(id.f3),
        .id_funct7_5(id.f7), .ex_flush(flush),
        .ex_valid(s_valid), .ex_branch(s_branch), .ex_MemRead(s_MemRead),
        .ex_MemtoReg(s_MemtoReg), .ex_MemWrite(s_MemWrite), .ex_ALUsrc(s_ALUsrc),
        .ex_RegWrite(s_RegWrite), .ex_ALUop(s_ALUop), .ex_pc(s_pc),
        .ex_rs1_data(s_rs1_data), .ex_rs2_data(s_rs2_data), .ex_imm(s_imm),
        .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_rd(s_rd), .ex_funct3(s_funct3),
        .ex_funct7_5(s_funct7_5), .stall(s_stall), .stall_cnt(s_stall_cnt),
        .flush_cnt(s_flush_cnt)
    );

    function automatic int sat(input int c, input int maxv);
        return (c < maxv) ? c + 1 : c;
    endfunction

    function automatic st_t rand_id();
        st_t r;
        logic [31:0] u;
        u = $urandom;
        r = '0;
        r.valid    = (u[3:0] != 4'd0);
        r.branch   = u[4];
        r.memread  = u[5];
        r.memtoreg = u[6];
        r.memwrite = u[7];
        r.alusrc   = u[8];
        r.regwrite = u[9];
        r.aluop    = u[11:10];
        r.f3       = u[14:12];
        r.f7       = u[15];
        r.pc       = $urandom;
        r.rs1d     = $urandom;
        r.rs2d     = $urandom;
        r.imm      = $urandom;
        r.rs1      = 5'($urandom_range(0, 7));
        r.rs2      = 5'($urandom_range(0, 7));
        r.rd       = 5'($urandom_range(0, 7));
        return r;
    endfunction

    // One clock: check the combinational stall, advance the model, check outputs
    task automatic cycle();
        logic exp_hz, exp_stall;
        #1;
        exp_hz = exp.valid && exp.memread && id.valid && (exp.rd != 5'd0) &&
                 ((exp.rd == id.rs1) || (exp.rd == id.rs2));
        exp_stall = exp_hz && !flush;
        checks++;
        if (stall !== exp_stall || s_stall !== exp_stall) begin
            errors++;
            $display("FAIL stall: got %b/%b want %b", stall, s_stall, exp_stall);
        end
        @(posedge clk);
        if (rst) begin
            exp = '0; scnt = 0; fcnt = 0; scnt2 = 0; fcnt2 = 0;
        end else if (flush) begin
            exp = '0; fcnt = sat(fcnt, 65535); fcnt2 = sat(fcnt2, 3);
        end else if (exp_hz) begin
            exp = '0; scnt = sat(scnt, 65535); scnt2 = sat(scnt2, 3);
        end else begin
            exp = id;
            if (!id.valid) begin
                exp.branch = 0; exp.memread = 0; exp.memtoreg = 0; exp.memwrite = 0;
                exp.alusrc = 0; exp.regwrite = 0; exp.aluop = 2'b00;
            end
        end
        #1;
        checks++;
        if (act !== exp || s_act !== exp) begin
            errors++;
            $display("FAIL ex_regs: got %h sat %h want %h", act, s_act, exp);
        end
        checks++;
        if (stall_cnt !== 16'(scnt) || flush_cnt !== 16'(fcnt) ||
            s_stall_cnt !== 2'(scnt2) || s_flush_cnt !== 2'(fcnt2)) begin
            errors++;
            $display("FAIL counters: got s%0d f%0d s2 %0d f2 %0d want s%0d f%0d s2 %0d f2 %0d",
                     stall_cnt, flush_cnt, s_stall_cnt, s_flush_cnt, scnt, fcnt, scnt2, fcnt2);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            id = rand_id();
            cycle();
        end
        rst = 1'b0;
        id = '0; id.valid = 1'b1; id.regwrite = 1'b1; id.rd = 5'd5;
        cycle();
        checks++;
        if (ex_RegWrite !== 1'b1 || ex_rd !== 5'd5 || ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: got rw %b rd %0d v %b want 1 5 1", ex_RegWrite, ex_rd, ex_valid);
        end
    endtask

    task automatic test_load_use();
        id = '0; id.valid = 1'b1; id.memread = 1'b1; id.regwrite = 1'b1; id.rd = 5'd7;
        cycle();
        id = '0; id.valid = 1'b1; id.regwrite = 1'b1; id.rs1 = 5'd7; id.rs2 = 5'd2; id.rd = 5'd8;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL load_use_stall: got %b want 1", stall);
        end
        cycle();
        checks++;
        if (ex_valid !== 1'b0 || ex_RegWrite !== 1'b0 || stall !== 1'b0 || stall_cnt !== 16'd1) begin
            errors++;
            $display("FAIL load_use_bubble: got v %b rw %b st %b cnt %0d want 0 0 0 1",
                     ex_valid, ex_RegWrite, stall, stall_cnt);
        end
        cycle();
        checks++;
        if (ex_rd !== 5'd8 || ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL load_use_capture: got rd %0d v %b want 8 1", ex_rd, ex_valid);
        end
    endtask

    task automatic test_x0_nonmatch();
        id = '0; id.valid = 1'b1; id.memread = 1'b1; id.rd = 5'd0;
        cycle();
        id = '0; id.valid = 1'b1; id.memread = 1'b1; id.rd = 5'd3; id.rs1 = 5'd0;
        cycle();
        id = '0; id.valid = 1'b1; id.rs1 = 5'd4; id.rs2 = 5'd5; id.rd = 5'd6;
        cycle();
        checks++;
        if (ex_rs1 !== 5'd4 || ex_rs2 !== 5'd5 || ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL nonmatch_capture: got rs1 %0d rs2 %0d v %b want 4 5 1", ex_rs1, ex_rs2, ex_valid);
        end
    endtask

    task automatic test_flush_priority();
        int s0, f0;
        id = '0; id.valid = 1'b1; id.memread = 1'b1; id.rd = 5'd7;
        cycle();
        s0 = int'(stall_cnt); f0 = int'(flush_cnt);
        id = '0; id.valid = 1'b1; id.rs2 = 5'd7; id.memwrite = 1'b1;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        checks++;
        if (int'(flush_cnt) != f0 + 1 || int'(stall_cnt) != s0 || ex_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_priority: got f %0d s %0d v %b want f %0d s %0d v 0",
                     flush_cnt, stall_cnt, ex_valid, f0 + 1, s0);
        end
    endtask

    task automatic test_invalid_slot();
        id = '0; id.valid = 1'b0; id.memwrite = 1'b1; id.regwrite = 1'b1; id.rd = 5'd9;
        cycle();
        checks++;
        if (ex_valid !== 1'b0 || ex_MemWrite !== 1'b0 || ex_RegWrite !== 1'b0 || ex_rd !== 5'd9) begin
            errors++;
            $display("FAIL invalid_slot: got v %b mw %b rw %b rd %0d want 0 0 0 9",
                     ex_valid, ex_MemWrite, ex_RegWrite, ex_rd);
        end
    endtask

    task automatic test_saturation();
        int seq [5] = '{1, 2, 3, 3, 3};
        rst = 1'b1; id = rand_id();
        cycle();
        rst = 1'b0; flush = 1'b1;
        for (int i = 0; i < 5; i++) begin
            id = rand_id();
            cycle();
            checks++;
            if (int'(s_flush_cnt) != seq[i]) begin
                errors++;
                $display("FAIL saturation[%0d]: got %0d want %0d", i, s_flush_cnt, seq[i]);
            end
        end
        flush = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            id = rand_id();
            flush = ($urandom_range(0, 5) == 0);
            rst = ($urandom_range(0, 49) == 0);
            cycle();
        end
        rst = 1'b0; flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp = '0; scnt = 0; fcnt = 0; scnt2 = 0; fcnt2 = 0;
        rst = 1'b1; flush = 1'b0; id = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_x0_nonmatch();
        test_flush_priority();
        test_invalid_slot();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_hazard_reg.md
Name: id_ex_hazard_reg

Overview:
ID/EX pipeline register for the 5-stage RV32I core, with an integrated load-use hazard detector. It sits directly downstream of the main control decoder. It latches that decoder's eight control bits along with decoded operands and register fields. It also generates the IF/ID/PC stall and inserts bubbles on load-use hazards and on EX-stage branch/jump flushes.

Parameters:
XLEN, 32, datapath width of PC, register data and immediate
CNT_W, 16, width of saturating stall/flush event counters

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
id_valid  in  1  ID stage holds a real instruction
id_branch, id_MemRead, id_MemtoReg, id_MemWrite, id_ALUsrc, id_RegWrite  in  1 each  control bits from decoder
id_ALUop  in  2  ALU op class from decoder
id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN each  decoded operands
id_rs1, id_rs2, id_rd  in  5 each  register indices
id_funct3  in  3  funct3 field
id_funct7_5  in  1  instr bit 30
ex_flush  in  1  branch/jump taken resolved in EX this cycle
ex_valid  out  1  EX holds a real instruction
ex_branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUsrc, ex_RegWrite  out  1 each  registered control
ex_ALUop  out  2  registered ALU op class
ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN each  registered operands
ex_rs1, ex_rs2, ex_rd  out  5 each  registered indices (for forwarding unit)
ex_funct3  out  3  registered funct3
ex_funct7_5  out  1  registered bit 30
stall  out  1  combinational: hold PC and IF/ID this cycle
stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

Behaviour:
- Reset (rst=1 at a clk edge): all ex_* outputs are 0, including ex_valid. stall_cnt and flush_cnt are 0. rst overrides every other input.
- Hazard term (combinational): hz = ex_valid & ex_MemRead & id_valid & (ex_rd != 0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).
- stall = hz & ~ex_flush. A flush discards the ID instruction, so no stall is needed under a flush.
- Per clock edge, with rst=0, in this priority order:
  1. ex_flush=1: load a bubble and increment flush_cnt.
  2. Else hz=1: load a bubble and increment stall_cnt.
  3. Else: capture all id_* fields into ex_*. ex_valid <= id_valid.
- Bubble: ex_valid and all eight control bits are 0. All data and index fields are 0, so a bubble never writes the regfile or memory and never matches in forwarding (ex_rd=0).
- Capture when id_valid=0: data fields are captured as presented. The control bits are forced to 0 so an invalid slot cannot assert RegWrite/MemWrite/MemRead/branch.
- Latency: exactly 1 cycle from ID inputs to EX outputs. No internal buffering beyond a single stage.
- Load-use stall lasts exactly one cycle per hazard. On the next cycle ex_MemRead=0 (bubble), so hz drops. No state machine beyond the register itself.
- Counters: increment by 1 per event cycle and saturate at all-ones (no wrap). Both counters never increment in the same cycle, because flush wins.
- A hazard against x0 is ignored (ex_rd=0 suppresses it). A store/branch using rs2 is hazard-checked like any other consumer, as a conservative rule.
- Simultaneous flush and hazard: the bubble is loaded, stall=0, only flush_cnt increments.
- Reset asserted mid-stall: the next edge clears everything. stall falls combinationally because ex_valid becomes 0.

Test Plan:
- Reset: hold rst 2 cycles with random id_* -> all ex_* = 0, stall=0, counters=0. Release with id_valid=1, id_RegWrite=1, id_rd=5 -> next cycle ex_RegWrite=1, ex_rd=5, ex_valid=1.
- Load-use: load with rd=7 in EX (ex_MemRead=1); ID add with rs1=7 -> stall=1 that cycle, next cycle bubble (ex_valid=0, ex_RegWrite=0), stall=0, stall_cnt=1. The add is captured one cycle later.
- x0 and non-match: load with rd=0, ID rs1=0 -> stall=0. Load with rd=3, ID rs1=4/rs2=5 -> stall=0, normal capture.
- Flush priority: ex_flush=1 with a load-use hazard present -> stall=0, bubble loaded, flush_cnt=1, stall_cnt unchanged.
- Invalid slot: id_valid=0, id_MemWrite=1, id_rd=9 -> ex_valid=0, ex_MemWrite=0.
- Saturation: CNT_W=2, force 5 consecutive flushes -> flush_cnt reads 1,2,3,3,3.
